// File: rtl/mole_hit_judge_pkg.sv
// mole_hit_judge_pkg: shared game states, default timing constants and hole decode helper.
package mole_hit_judge_pkg;
    typedef enum logic [1:0] {IDLE, GAP, UP, OVER} state_t;
    localparam int DEF_UP_TICKS   = 50;
    localparam int DEF_GAP_TICKS  = 20;
    localparam int DEF_MAX_MISSES = 3;
    function automatic logic [4:0] hole_onehot(input logic [2:0] h);
        return (h >= 3'd1 && h <= 3'd5) ? 5'b1 << (h - 3'd1) : 5'b0;
    endfunction
endpackage

// File: rtl/mole_hit_judge_btn_edge_detect.sv
// btn_edge_detect: registered rising-edge detector for the five player buttons.
module btn_edge_detect (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] buttons,
    output logic [4:0] rise
);
    logic [4:0] prev;
    always_ff @(posedge clk or posedge reset)
        if (reset) prev <= '0;
        else       prev <= buttons;
    assign rise = buttons & ~prev;
endmodule

// File: rtl/mole_hit_judge.sv
// mole_hit_judge: whack-a-mole game FSM raising moles, timing them out and scoring hits and misses.
module mole_hit_judge
    import mole_hit_judge_pkg::*;
#(
    parameter int UP_TICKS   = DEF_UP_TICKS,
    parameter int GAP_TICKS  = DEF_GAP_TICKS,
    parameter int MAX_MISSES = DEF_MAX_MISSES
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       start,
    input  logic [2:0] hole,
    input  logic [4:0] buttons,
    output logic [4:0] mole_leds,
    output logic [7:0] score,
    output logic [3:0] misses,
    output logic       game_over,
    output logic       busy
);
    state_t     state;
    logic [7:0] gap_cnt, up_cnt;
    logic [4:0] rise, hole_oh;
    logic [3:0] miss_next;
    logic       hit, wrong, timeout;
    btn_edge_detect u_edge (.clk(clk), .reset(reset), .buttons(buttons), .rise(rise));
    // mole_leds doubles as the latched hole, so hits and wrong presses are judged against it
    assign hole_oh   = hole_onehot(hole);
    assign hit       = |(rise & mole_leds);
    assign wrong     = |(rise & ~mole_leds);
    assign timeout   = tick && up_cnt == 8'd1;
    assign miss_next = misses + 4'd1;
    assign game_over = state == OVER;
    assign busy      = state == GAP || state == UP;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            mole_leds <= '0;
            score     <= '0;
            misses    <= '0;
            gap_cnt   <= '0;
            up_cnt    <= '0;
        end else begin
            case (state)
                IDLE, OVER: if (start) begin
                    score   <= '0;
                    misses  <= '0;
                    gap_cnt <= 8'(GAP_TICKS);
                    state   <= GAP;
                end
                GAP: if (tick) begin
                    if (gap_cnt > 8'd1) gap_cnt <= gap_cnt - 8'd1;
                    else begin
                        gap_cnt <= '0;
                        if (|hole_oh) begin
                            mole_leds <= hole_oh;
                            up_cnt    <= 8'(UP_TICKS);
                            state     <= UP;
                        end
                    end
                end
                UP: begin
                    if (tick && up_cnt != 8'd0) up_cnt <= up_cnt - 8'd1;
                    if (hit) begin
                        score     <= score == 8'hFF ? score : score + 8'd1;
                        mole_leds <= '0;
                        gap_cnt   <= 8'(GAP_TICKS);
                        state     <= GAP;
                    end else if (wrong || timeout) begin
                        misses    <= miss_next;
                        mole_leds <= '0;
                        gap_cnt   <= 8'(GAP_TICKS);
                        state     <= miss_next == 4'(MAX_MISSES) ? OVER : GAP;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mole_hit_judge.sv
// tb_mole_hit_judge: directed and random stimulus, scoreboard checked against a game-rule reference model.
module tb_mole_hit_judge;
    localparam int GT = 2, UT = 3, MM = 3;
    logic       clk = 0, reset = 1, tick = 0, start = 0;
    logic [2:0] hole = 0;
    logic [4:0] buttons = 0;
    logic [4:0] mole_leds;
    logic [7:0] score;
    logic [3:0] misses;
    logic       game_over, busy;
    typedef struct packed {
        logic [4:0] leds;
        logic [7:0] score;
        logic [3:0] misses;
        logic       over;
        logic       busy;
    } exp_t;
    exp_t q[$];
    int n_checks = 0, n_fail = 0;
    int ph, left, mole, hits, missed;
    logic [4:0] last;

    mole_hit_judge #(.UP_TICKS(UT), .GAP_TICKS(GT), .MAX_MISSES(MM)) dut (
        .clk(clk), .reset(reset), .tick(tick), .start(start), .hole(hole), .buttons(buttons),
        .mole_leds(mole_leds), .score(score), .misses(misses), .game_over(game_over), .busy(busy)
    );

    always #5 clk = ~clk;

    // phases: 0 idle, 1 waiting for a mole, 2 mole raised, 3 game over
    task automatic model_step(input logic t, input logic s, input int h, input logic [4:0] b);
        bit hit, wrong;
        hit = 0;
        wrong = 0;
        for (int k = 1; k <= 5; k++)
            if (b[k-1] && !last[k-1]) begin
                if (k == mole) hit = 1;
                else wrong = 1;
            end
        if ((ph == 0 || ph == 3) && s) begin
            hits = 0; missed = 0; ph = 1; left = GT;
        end else if (ph == 1 && t) begin
            if (left > 1) left--;
            else begin
                left = 0;
                if (h >= 1 && h <= 5) begin mole = h; ph = 2; left = UT; end
            end
        end else if (ph == 2) begin
            if (hit) begin
                hits = hits < 255 ? hits + 1 : 255; mole = 0; ph = 1; left = GT;
            end else if (wrong || (t && left == 1)) begin
                missed++; mole = 0; ph = (missed == MM) ? 3 : 1; left = GT;
            end else if (t) left--;
        end
        last = b;
    endtask

    function automatic exp_t model_exp();
        exp_t e;
        e.leds   = mole == 0 ? 5'd0 : 5'(1 << (mole - 1));
        e.score  = 8'(hits);
        e.misses = 4'(missed);
        e.over   = ph == 3;
        e.busy   = ph == 1 || ph == 2;
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic step(input logic t, input logic s, input logic [2:0] h, input logic [4:0] b);
        @(negedge clk);
        reset = 0; tick = t; start = s; hole = h; buttons = b;
        model_step(t, s, int'(h), b);
        q.push_back(model_exp());
    endtask

    task automatic rst_cycle();
        @(negedge clk);
        reset = 1; tick = 0; start = 0;
        #1;
        check("async_reset", 32'({mole_leds, score, misses, game_over, busy}), 32'd0);
        ph = 0; left = 0; mole = 0; hits = 0; missed = 0; last = '0;
        q.push_back(model_exp());
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        exp_t e, g;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                g = {mole_leds, score, misses, game_over, busy};
                n_checks++;
                if (g !== e) begin
                    n_fail++;
                    $display("FAIL scoreboard t=%0t: got leds=%b score=%0d misses=%0d over=%b busy=%b, expected leds=%b score=%0d misses=%0d over=%b busy=%b",
                             $time, g.leds, g.score, g.misses, g.over, g.busy, e.leds, e.score, e.misses, e.over, e.busy);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "timeout");
    end

    initial begin
        logic [4:0] b;
        rst_cycle();
        rst_cycle();
        // first mole on hole 3, then hit it
        step(1, 1, 3, 0);
        step(1, 0, 3, 0);
        step(1, 0, 3, 0);
        after_edge();
        check("mole_up", 32'(mole_leds), 32'(5'b00100));
        step(1, 0, 3, 5'b00100);
        after_edge();
        check("first_hit", 32'({score, mole_leds}), 32'({8'd1, 5'd0}));
        // three unanswered moles end the game
        repeat (15) step(1, 0, 4, 0);
        after_edge();
        check("game_over", 32'({game_over, busy, misses}), 32'({1'b1, 1'b0, 4'd3}));
        // correct and wrong presses in the same cycle count as a hit
        step(1, 1, 2, 0);
        step(1, 0, 2, 0);
        step(1, 0, 2, 0);
        step(1, 0, 2, 5'b00011);
        after_edge();
        check("hit_wins", 32'({score, misses}), 32'({8'd1, 4'd0}));
        // invalid holes keep the game waiting
        step(1, 0, 2, 0);
        step(1, 0, 0, 0);
        step(1, 0, 7, 0);
        after_edge();
        check("invalid_hole_wait", 32'({busy, mole_leds}), 32'({1'b1, 5'd0}));
        step(1, 0, 5, 0);
        after_edge();
        check("hole5_mole", 32'(mole_leds), 32'(5'b10000));
        step(1, 0, 5, 5'b10000);
        // saturate the score
        repeat (256) begin
            step(1, 0, 1, 0);
            step(1, 0, 1, 0);
            step(1, 0, 1, 5'b00001);
        end
        after_edge();
        check("score_saturated", 32'(score), 32'd255);
        // a button held from the last hit cannot hit the next mole
        repeat (6) step(1, 0, 1, 5'b00001);
        after_edge();
        check("held_button_miss", 32'({score, misses}), 32'({8'd255, 4'd1}));
        step(1, 0, 1, 0);
        // reset mid-mole abandons the game
        rst_cycle();
        step(0, 1, 3, 0);
        repeat (4) begin
            step(1, 0, 3, 0);
            step(1, 0, 3, 0);
            step(1, 0, 3, 5'b00100);
        end
        step(1, 0, 3, 0);
        step(1, 0, 3, 0);
        after_edge();
        check("pre_reset", 32'({score, mole_leds}), 32'({8'd4, 5'b00100}));
        rst_cycle();
        step(0, 1, 3, 0);
        step(0, 0, 3, 0);
        after_edge();
        check("restart", 32'({score, misses, busy}), 32'({8'd0, 4'd0, 1'b1}));
        // random play
        b = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) == 0) rst_cycle();
            else begin
                if ($urandom_range(0, 9) == 0) b = 5'($urandom);
                else if ($urandom_range(0, 2) == 0) b = b ^ 5'(1 << $urandom_range(0, 4));
                step($urandom_range(0, 1) == 1, $urandom_range(0, 99) < 4, 3'($urandom_range(0, 7)), b);
            end
        end
        repeat (3) @(posedge clk);
        #2;
        check("queue_drained", 32'(q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
